// File: rtl/comparator_pkg.sv
// Shared definitions for the chunked magnitude comparator: FSM encoding and
// the parameter-legality rules that the top checks at elaboration.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 4;
    localparam int MIN_CHUNK = 1;

    // WIDTH must split into whole chunks and be at least MIN_WIDTH bits.
    function automatic bit cfg_legal(input int width, input int chunk);
        return (chunk >= MIN_CHUNK) && (width >= MIN_WIDTH) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_compare.sv
// Combinational CHUNK-wide unsigned magnitude compare; zero latency, no flow control.
// invert_msb flips the top bit of both operands so a two's-complement slice orders correctly.
module chunk_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         invert_msb,
    output logic         gt,
    output logic         lt
);

    localparam logic [W-1:0] MSB_MASK = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;

    assign w_a = invert_msb ? (a ^ MSB_MASK) : a;
    assign w_b = invert_msb ? (b ^ MSB_MASK) : b;

    assign gt = (w_a > w_b);
    assign lt = (w_a < w_b);

endmodule

// File: rtl/chunked_magnitude_comparator.sv
// Multi-cycle A/B magnitude compare, one CHUNK per cycle from the MSB end, stopping at the first
// differing chunk: done follows start by k+1 cycles (N if equal); start is ignored while busy.
module chunked_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             SIGNED_MODE,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             GT,
    output logic             LT,
    output logic             EQ
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (!cfg_legal(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("chunked_magnitude_comparator: WIDTH must be >= 4 and a multiple of CHUNK");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_gt;
    logic               r_lt;
    logic               r_eq;

    logic [CHUNK-1:0]   w_a_chunk;
    logic [CHUNK-1:0]   w_b_chunk;
    logic               w_invert;
    logic               w_gt;
    logic               w_lt;
    logic               w_last;

    // Chunk 0 is the most-significant slice of the operand.
    always_comb begin
        w_a_chunk = '0;
        w_b_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_chunk = r_a[WIDTH-1-k*CHUNK -: CHUNK];
                w_b_chunk = r_b[WIDTH-1-k*CHUNK -: CHUNK];
            end
        end
    end

    assign w_invert = r_signed && (r_idx == '0);
    assign w_last   = (r_idx == IDX_W'(N-1));

    chunk_compare #(
        .W (CHUNK)
    ) u_chunk_compare (
        .a          (w_a_chunk),
        .b          (w_b_chunk),
        .invert_msb (w_invert),
        .gt         (w_gt),
        .lt         (w_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_signed <= SIGNED_MODE;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Result flags only move on DONE entry so they hold while busy.
                    if (w_gt || w_lt) begin
                        r_gt    <= w_gt;
                        r_lt    <= w_lt;
                        r_eq    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_last) begin
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign GT   = r_gt;
    assign LT   = r_lt;
    assign EQ   = r_eq;

endmodule

// File: tb/tb_chunked_magnitude_comparator.sv
// Bench for chunked_magnitude_comparator (WIDTH=16, CHUNK=4): directed table, corner sequences,
// and random operands scored against an arithmetic reference.
module tb_chunked_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             SIGNED_MODE;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             GT;
    logic             LT;
    logic             EQ;

    int n_checks;
    int n_fail;

    chunked_magnitude_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .SIGNED_MODE (SIGNED_MODE),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .GT          (GT),
        .LT          (LT),
        .EQ          (EQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic             sm;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             gt;
        logic             lt;
        logic             eq;
        int               lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-width arithmetic compare; latency from the first differing nibble.
    function automatic void model(input logic sm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic gt, output logic lt, output logic eq, output int lat);
        logic signed [WIDTH:0] ea;
        logic signed [WIDTH:0] eb;
        logic [WIDTH-1:0] ca;
        logic [WIDTH-1:0] cb;
        ea  = sm ? {a[WIDTH-1], a} : {1'b0, a};
        eb  = sm ? {b[WIDTH-1], b} : {1'b0, b};
        gt  = (ea > eb);
        lt  = (ea < eb);
        eq  = (ea == eb);
        lat = N;
        for (int k = N - 1; k >= 0; k--) begin
            ca = (a >> (WIDTH - CHUNK * (k + 1))) & 16'h000F;
            cb = (b >> (WIDTH - CHUNK * (k + 1))) & 16'h000F;
            if (ca != cb) lat = k + 1;
        end
    endfunction

    task automatic drive_start(input logic sm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start       = 1'b1;
        SIGNED_MODE = sm;
        A           = a;
        B           = b;
    endtask

    // Waits for done after a start was driven; scrambles inputs after the start edge.
    task automatic wait_result(output logic gt, output logic lt, output logic eq,
                               output int lat, output int bcnt, input bit mid_pulse);
        logic pg, pl, pe;
        bit   got;
        pg = GT; pl = LT; pe = EQ;
        @(posedge clk); #1;
        start       = 1'b0;
        A           = 16'($urandom);
        B           = 16'($urandom);
        SIGNED_MODE = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        chk("hold_while_busy", {29'd0, GT, LT, EQ}, {29'd0, pg, pl, pe});
        for (int i = 0; i < 40 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bcnt++;
                start = mid_pulse && (i == 1);
                if (mid_pulse && i == 1) begin
                    A = 16'hFFFF;
                    B = 16'h0000;
                end
                @(posedge clk); #1;
                lat++;
            end
        end
        start = 1'b0;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        gt = GT; lt = LT; eq = EQ;
    endtask

    initial begin
        logic gt, lt, eq, egt, elt, eeq;
        int   lat, bcnt, elat;
        bit   seen;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; SIGNED_MODE = 1'b0; A = '0; B = '0;

        vecs.push_back('{1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{1'b1, 16'h7FFF, 16'h7FFE, 1'b1, 1'b0, 1'b0, 4});
        vecs.push_back('{1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 4});
        vecs.push_back('{1'b0, 16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, 2});
        vecs.push_back('{1'b1, 16'hF0F0, 16'hF0E0, 1'b1, 1'b0, 1'b0, 3});
        vecs.push_back('{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 4});

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_gt",   {31'd0, GT},   32'd0);
        chk("rst_lt",   {31'd0, LT},   32'd0);
        chk("rst_eq",   {31'd0, EQ},   32'd1);

        // Start on the very first edge after release; equal operands.
        @(negedge clk);
        rst_n = 1'b1;
        drive_start(1'b0, 16'h1234, 16'h1234);
        wait_result(gt, lt, eq, lat, bcnt, 1'b0);
        chk("eq1234_flags", {29'd0, gt, lt, eq}, 32'b001);
        chk("eq1234_lat",   lat,  32'd4);
        chk("eq1234_busy",  bcnt, 32'd4);
        @(posedge clk); #1;
        chk("done_one_cycle", {30'd0, done, busy}, 32'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive_start(vecs[i].sm, vecs[i].a, vecs[i].b);
            wait_result(gt, lt, eq, lat, bcnt, 1'b0);
            chk($sformatf("vec%0d_flags", i), {29'd0, gt, lt, eq}, {29'd0, vecs[i].gt, vecs[i].lt, vecs[i].eq});
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        // Back-to-back: second start held while in DONE, no idle cycle.
        @(negedge clk);
        drive_start(1'b0, 16'h1235, 16'h1234);
        wait_result(gt, lt, eq, lat, bcnt, 1'b0);
        chk("b2b_first_flags", {29'd0, gt, lt, eq}, 32'b100);
        chk("b2b_first_lat", lat, 32'd4);
        drive_start(1'b0, 16'h0010, 16'h0100);
        wait_result(gt, lt, eq, lat, bcnt, 1'b0);
        chk("b2b_second_flags", {29'd0, gt, lt, eq}, 32'b010);
        chk("b2b_second_lat", lat, 32'd2);
        chk("b2b_second_busy", bcnt, 32'd2);

        // Start pulse during RUN must be ignored.
        @(negedge clk);
        drive_start(1'b0, 16'h0001, 16'h0002);
        wait_result(gt, lt, eq, lat, bcnt, 1'b1);
        chk("ignore_start_flags", {29'd0, gt, lt, eq}, 32'b010);
        chk("ignore_start_lat", lat, 32'd4);

        // Reset mid-RUN aborts the comparison.
        @(negedge clk);
        drive_start(1'b0, 16'h00FF, 16'h00FE);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_flags", {29'd0, GT, LT, EQ}, 32'b001);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 150; i++) begin
            logic [WIDTH-1:0] ra, rb;
            logic             rsm;
            ra  = 16'($urandom);
            rsm = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (16'h0001 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            model(rsm, ra, rb, egt, elt, eeq, elat);
            @(negedge clk);
            drive_start(rsm, ra, rb);
            wait_result(gt, lt, eq, lat, bcnt, 1'b0);
            chk($sformatf("rnd%0d_flags a=%h b=%h s=%0d", i, ra, rb, rsm),
                {29'd0, gt, lt, eq}, {29'd0, egt, elt, eeq});
            chk($sformatf("rnd%0d_lat a=%h b=%h", i, ra, rb), lat, elat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
